// File: rtl/instr_fetch_assembler.sv
// Fetches four consecutive bytes from a byte-wide memory with one-cycle read latency and assembles a 32-bit word; valid pulses 5 cycles after the request edge.
// No backpressure: requests while busy are dropped. FETCH_BYTESWAP_EN selects big-endian assembly (default little-endian).
module instr_fetch_assembler #(
   parameter int          ADDR_W      = 32,
   parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
   input  logic              clk_i_top,
   input  logic              rst_n_top,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              flush_i,
   input  logic [7:0]        instr8bit_i,
   output logic [ADDR_W-1:0] adr_o,
   output logic              mem_write_o,
   output logic              busy_o,
   output logic              instr_valid_o,
   output logic [31:0]       instr_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_B0   = 3'd1,
      S_B1   = 3'd2,
      S_B2   = 3'd3,
      S_B3   = 3'd4,
      S_WB   = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_base;
   logic [23:0]         r_shadow;
   logic [31:0]         r_instr;
   logic                r_valid;
   logic [ADDR_W-1:0]   w_adr;
   logic                w_done;
   logic                w_flush;
   logic [31:0]         w_word;

   assign w_flush = flush_i && (r_state != S_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_adr       = pc_i;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_adr = pc_i;
            if (fetch_req_i) w_state_nxt = S_B0;
         end
         S_B0: begin
            w_adr       = r_base;
            w_state_nxt = S_B1;
         end
         S_B1: begin
            w_adr       = r_base + ADDR_W'(1);
            w_state_nxt = S_B2;
         end
         S_B2: begin
            w_adr       = r_base + ADDR_W'(2);
            w_state_nxt = S_B3;
         end
         S_B3: begin
            w_adr       = r_base + ADDR_W'(3);
            w_state_nxt = S_WB;
         end
         S_WB: begin
            w_adr       = r_base + ADDR_W'(3);
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // Flush beats completion: the word in flight is discarded.
      if (w_flush) begin
         w_state_nxt = S_IDLE;
         w_done      = 1'b0;
      end
   end

`ifdef FETCH_BYTESWAP_EN
   assign w_word = {r_shadow[7:0], r_shadow[15:8], r_shadow[23:16], instr8bit_i};
`else
   assign w_word = {instr8bit_i, r_shadow};
`endif

   always_ff @(posedge clk_i_top or negedge rst_n_top) begin
      if (!rst_n_top) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_shadow <= '0;
         r_instr  <= RESET_INSTR;
         r_valid  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_done;
         if (r_state == S_IDLE && fetch_req_i) r_base <= pc_i;
         // Read data lags the address by one cycle, so each byte lands one state late.
         if (!w_flush) begin
            case (r_state)
               S_B1:    r_shadow[7:0]   <= instr8bit_i;
               S_B2:    r_shadow[15:8]  <= instr8bit_i;
               S_B3:    r_shadow[23:16] <= instr8bit_i;
               default: ;
            endcase
         end
         if (w_done) r_instr <= w_word;
      end
   end

   assign adr_o         = w_adr;
   assign mem_write_o   = 1'b0;
   assign busy_o        = (r_state != S_IDLE);
   assign instr_valid_o = r_valid;
   assign instr_o       = r_instr;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Scoreboard bench for instr_fetch_assembler: expected words are queued at request time, a monitor pops them on each valid pulse.
module tb_instr_fetch_assembler;

   logic        clk_i_top = 1'b0;
   logic        rst_n_top = 1'b0;
   logic        fetch_req_i = 1'b0;
   logic [31:0] pc_i = 32'h0;
   logic        flush_i = 1'b0;
   logic [7:0]  instr8bit_i = 8'h0;
   logic [31:0] adr_o;
   logic        mem_write_o;
   logic        busy_o;
   logic        instr_valid_o;
   logic [31:0] instr_o;

   int          tests = 0;
   int          fails = 0;
   int          n_valid = 0;
   int          nv;
   logic [31:0] sb[$];

`ifdef FETCH_BYTESWAP_EN
   localparam logic [31:0] W0 = 32'h2020_8500;
   localparam logic [31:0] W1 = 32'h1122_3344;
   localparam logic [31:0] WW = 32'hAABB_2020;
`else
   localparam logic [31:0] W0 = 32'h0085_2020;
   localparam logic [31:0] W1 = 32'h4433_2211;
   localparam logic [31:0] WW = 32'h2020_BBAA;
`endif

   instr_fetch_assembler dut (
      .clk_i_top     (clk_i_top),
      .rst_n_top     (rst_n_top),
      .fetch_req_i   (fetch_req_i),
      .pc_i          (pc_i),
      .flush_i       (flush_i),
      .instr8bit_i   (instr8bit_i),
      .adr_o         (adr_o),
      .mem_write_o   (mem_write_o),
      .busy_o        (busy_o),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o)
   );

   always #5 clk_i_top = ~clk_i_top;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 8'h20;
         32'h0000_0001: return 8'h20;
         32'h0000_0002: return 8'h85;
         32'h0000_0003: return 8'h00;
         32'h0000_0004: return 8'h11;
         32'h0000_0005: return 8'h22;
         32'h0000_0006: return 8'h33;
         32'h0000_0007: return 8'h44;
         32'hFFFF_FFFE: return 8'hAA;
         32'hFFFF_FFFF: return 8'hBB;
         default:       return 8'hEE;
      endcase
   endfunction

   // Registered-read instruction memory
   always @(posedge clk_i_top) instr8bit_i <= mem_byte(adr_o);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk_i_top) begin
      if (rst_n_top && instr_valid_o) begin
         n_valid++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got instr %h expected no pulse", instr_o);
         end else begin
            check("sb_instr", instr_o, sb.pop_front());
         end
      end
   end

   task automatic request(input logic [31:0] pc, input logic [31:0] exp_w,
                          input bit expect_done, input bit with_flush);
      fetch_req_i = 1'b1;
      pc_i        = pc;
      flush_i     = with_flush;
      if (expect_done) sb.push_back(exp_w);
      @(posedge clk_i_top);
      #1;
      fetch_req_i = 1'b0;
      flush_i     = 1'b0;
      pc_i        = 32'h0000_0300;
   endtask

   // Walks B0..WB after the request edge, then the valid cycle.
   task automatic fetch_seq(input logic [31:0] base, input logic [31:0] hold);
      logic [31:0] exp_adr[5];
      exp_adr[0] = base;
      exp_adr[1] = base + 32'd1;
      exp_adr[2] = base + 32'd2;
      exp_adr[3] = base + 32'd3;
      exp_adr[4] = base + 32'd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i_top);
         check("adr_seq", adr_o, exp_adr[k]);
         check("busy_in_fetch", 32'(busy_o), 32'd1);
         check("no_early_valid", 32'(instr_valid_o), 32'd0);
         check("instr_hold", instr_o, hold);
      end
      @(negedge clk_i_top);
      check("valid_on_time", 32'(instr_valid_o), 32'd1);
      check("idle_at_valid", 32'(busy_o), 32'd0);
   endtask

   initial begin
      pc_i      = 32'h0000_0123;
      rst_n_top = 1'b0;
      repeat (2) @(negedge clk_i_top);
      check("rst_instr", instr_o, 32'h0);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("mem_write", 32'(mem_write_o), 32'd0);
      check("idle_adr_pc", adr_o, 32'h0000_0123);
      rst_n_top = 1'b1;
      @(negedge clk_i_top);

      // basic fetch
      request(32'h0, W0, 1'b1, 1'b0);
      fetch_seq(32'h0, 32'h0);

      // back-to-back request in the valid cycle
      request(32'h4, W1, 1'b1, 1'b0);
      fetch_seq(32'h4, W0);

      // request while busy is ignored
      @(negedge clk_i_top);
      request(32'h0, W0, 1'b1, 1'b0);
      @(posedge clk_i_top); #1;
      @(posedge clk_i_top); #1;
      fetch_req_i = 1'b1;
      pc_i        = 32'h4;
      @(posedge clk_i_top); #1;
      fetch_req_i = 1'b0;
      nv = n_valid;
      repeat (10) @(negedge clk_i_top);
      check("ignored_req_pulses", 32'(n_valid - nv), 32'd1);
      check("ignored_req_instr", instr_o, W0);

      // flush in B3
      request(32'h4, 32'h0, 1'b0, 1'b0);
      @(posedge clk_i_top); #1;
      @(posedge clk_i_top); #1;
      @(posedge clk_i_top); #1;
      flush_i = 1'b1;
      @(posedge clk_i_top); #1;
      flush_i = 1'b0;
      @(negedge clk_i_top);
      check("flush_idle", 32'(busy_o), 32'd0);
      check("flush_instr", instr_o, W0);
      nv = n_valid;
      repeat (8) @(negedge clk_i_top);
      check("flush_no_valid", 32'(n_valid - nv), 32'd0);
      check("flush_instr_kept", instr_o, W0);

      // request with flush high in IDLE is accepted
      request(32'h4, W1, 1'b1, 1'b1);
      nv = n_valid;
      for (int k = 0; k < 12 && n_valid == nv; k++) @(negedge clk_i_top);
      check("post_flush_fetch", 32'(n_valid - nv), 32'd1);

      // address wrap
      @(negedge clk_i_top);
      request(32'hFFFF_FFFE, WW, 1'b1, 1'b0);
      fetch_seq(32'hFFFF_FFFE, W1);

      // reset mid-B2
      @(negedge clk_i_top);
      request(32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk_i_top); #1;
      @(posedge clk_i_top); #2;
      rst_n_top = 1'b0;
      #1;
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_instr", instr_o, 32'h0);
      check("midrst_valid", 32'(instr_valid_o), 32'd0);
      @(negedge clk_i_top);
      @(negedge clk_i_top);
      rst_n_top = 1'b1;
      nv = n_valid;
      repeat (8) @(negedge clk_i_top);
      check("midrst_no_valid", 32'(n_valid - nv), 32'd0);
      check("midrst_instr_after", instr_o, 32'h0);
      check("midrst_busy_after", 32'(busy_o), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_fetch_assembler.md
Name: instr_fetch_assembler

Overview:
- Fetch sequencer directly downstream of the byte-wide instruction memory in the multicycle MIPS.
- Drives four consecutive byte addresses, captures the 8-bit registered read data, and assembles a 32-bit instruction word for the decode/control stage.
- Presents a request/valid handshake to the controller. Holds the last completed instruction stable until the next fetch completes.

Parameters:
- ADDR_W, 32, width of byte address and PC.
- RESET_INSTR, 32'h0000_0000, value of instr_o after reset.

Ports:
- clk_i_top  in  1  system clock; all state updates on rising edge.
- rst_n_top  in  1  reset, asynchronous, active-low.
- fetch_req_i  in  1  start a fetch at pc_i; sampled in IDLE only.
- pc_i  in  ADDR_W  byte address of instruction byte 0.
- flush_i  in  1  abort an in-progress fetch.
- instr8bit_i  in  8  registered read data from instruction memory (1-cycle latency).
- adr_o  out  ADDR_W  byte address to instruction memory.
- mem_write_o  out  1  memory write enable; tied 0 by this block.
- busy_o  out  1  fetch in progress (state != IDLE).
- instr_valid_o  out  1  one-cycle pulse: instr_o updated this cycle.
- instr_o  out  32  last completed instruction word.

Behaviour:
- Reset (async, rst_n_top low):
  - state = IDLE; base = 0; shadow = 0.
  - instr_o = RESET_INSTR; instr_valid_o = 0; busy_o = 0.
- FSM states: IDLE, B0, B1, B2, B3, WB.
- IDLE:
  - adr_o = pc_i.
  - On an edge with fetch_req_i = 1: latch base = pc_i, go to B0.
- Address issue:
  - B0: adr_o = base.
  - B1: adr_o = base+1.
  - B2: adr_o = base+2.
  - B3 and WB: adr_o = base+3.
  - All additions are modulo 2^ADDR_W (wrap from all-ones to 0).
- Byte capture (one-cycle memory latency):
  - Edge leaving B1 stores instr8bit_i into shadow[7:0].
  - Leaving B2 stores shadow[15:8].
  - Leaving B3 stores shadow[23:16].
  - Leaving WB: instr_o = {instr8bit_i, shadow[23:0]}, instr_valid_o = 1 in the following cycle, state returns to IDLE.
- Latency:
  - Request edge E0 to instr_valid_o high is 5 cycles (valid in the cycle after E5).
  - Throughput: one instruction per 6 cycles with back-to-back requests.
- Back-to-back: fetch_req_i high in the cycle where instr_valid_o = 1 is accepted (state is IDLE).
- instr_valid_o is high for exactly one cycle per completed fetch. It is never asserted for aborted fetches.
- instr_o does not change during B0..WB; partial bytes live only in shadow.
- fetch_req_i while busy_o = 1 is ignored and not queued.
- pc_i changes while busy have no effect; base is used.
- Unaligned pc_i (pc_i[1:0] != 0) is legal; the fetch proceeds at byte granularity.
- flush_i:
  - When high at an edge in B0..WB: go to IDLE, shadow unchanged, instr_o unchanged, no valid pulse.
  - flush_i has priority over fetch completion in WB.
  - flush_i and fetch_req_i together in IDLE: request accepted (flush is a no-op in IDLE).
- Reset mid-fetch: immediate return to the reset values; no valid pulse.
- mem_write_o is constant 0.

Optional Feature:
- Macro: FETCH_BYTESWAP_EN.
- Defined: big-endian assembly. Byte at base goes to instr_o[31:24], base+1 to [23:16], base+2 to [15:8], base+3 to [7:0].
- Undefined: little-endian as above (byte at base in [7:0]).
- Timing and handshake are identical in both builds.

Test Plan:
- Reset: rst_n_top low mid-B2 -> immediate IDLE, instr_o = 0, busy_o = 0, no valid pulse after release.
- Basic fetch: bench memory bytes at 0..3 = 20,20,85,00; fetch_req_i with pc_i = 0 -> adr_o sequence 0,1,2,3,3. Valid 5 cycles after the request edge with instr_o = 32'h0085_2020 (32'h2020_8500 with FETCH_BYTESWAP_EN).
- Back-to-back: request pc = 0, then request pc = 4 in the valid cycle -> second valid exactly 6 cycles after the first. instr_o holds the first word until then.
- Ignored request: fetch_req_i pulsed in B2 with a different pc_i -> no extra fetch; a single valid with the original word.
- Flush: flush_i in B3 -> IDLE next cycle, no valid pulse, instr_o keeps its previous value. A new request then completes normally.
- Wrap: pc_i = 32'hFFFF_FFFE -> adr_o sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001; word assembled in that byte order.
